fpmul_arbiter: RTL and testbench

FPMUL_ARBITER -- requirements
Module: fpmul_arbiter

---
 rtl/fpmul_arbiter_pkg.sv | 7 +
 rtl/fpmul_arbiter_tag_fifo.sv | 48 ++++
 rtl/fpmul_arbiter.sv | 89 ++++++++
 tb/tb_fpmul_arbiter.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fpmul_arbiter_pkg.sv
// Shared types and constants for the two-requester FP multiplier arbiter.
package fpmul_arbiter_pkg;
   typedef enum logic {RUN = 1'b0, DRAIN = 1'b1} state_t;
   localparam int TAG_W         = 1;
   localparam int DEFAULT_DEPTH = 32;
   localparam int MUL_LATENCY   = 17;
endpackage

// File: rtl/fpmul_arbiter_tag_fifo.sv
// Circular tag FIFO; a push while full is taken only when a pop frees a slot in the same cycle.
module tag_fifo #(
   parameter int DEPTH = 32,
   parameter int WIDTH = 1
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic [WIDTH-1:0]           push_data,
   input  logic                       pop,
   output logic [WIDTH-1:0]           pop_data,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH+1)-1:0] count
);
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH+1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr, rd_ptr;
   logic             do_push, do_pop;

   assign full     = (count == CNT_W'(DEPTH));
   assign empty    = (count == '0);
   assign do_pop   = pop && !empty;
   assign do_push  = push && (!full || do_pop);
   assign pop_data = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= (wr_ptr == PTR_W'(DEPTH-1)) ? '0 : wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= (rd_ptr == PTR_W'(DEPTH-1)) ? '0 : rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end
endmodule

// File: rtl/fpmul_arbiter.sv
// Round-robin arbiter sharing one pipelined FP multiplier between two requesters;
// a tag FIFO routes in-order results back to the requester that issued them.
module fpmul_arbiter
   import fpmul_arbiter_pkg::*;
#(
   parameter int DEPTH = DEFAULT_DEPTH
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req0_valid,
   input  logic [31:0] req0_op1,
   input  logic [31:0] req0_op2,
   output logic        req0_ack,
   input  logic        req1_valid,
   input  logic [31:0] req1_op1,
   input  logic [31:0] req1_op2,
   output logic        req1_ack,
   output logic        mul_ready,
   output logic [31:0] mul_op1,
   output logic [31:0] mul_op2,
   input  logic        mul_done,
   input  logic [31:0] mul_res,
   output logic        res0_valid,
   output logic        res1_valid,
   output logic [31:0] res_data,
   input  logic        drain,
   output logic        idle,
   output logic        err
);
   state_t                     state, state_nxt;
   logic                       prio;   // 1: requester 1 wins a tie
   logic                       grant_ok, push, pop, full, empty;
   logic [TAG_W-1:0]           head_tag;
   logic [$clog2(DEPTH+1)-1:0] count;

   assign pop      = mul_done && !empty;
   assign grant_ok = rst && (state == RUN) && (!full || pop);
   assign req0_ack = grant_ok && req0_valid && (!req1_valid || !prio);
   assign req1_ack = grant_ok && req1_valid && !req0_ack;
   assign push     = req0_ack || req1_ack;
   assign idle     = !rst || ((count == '0) && !mul_ready);

   tag_fifo #(.DEPTH(DEPTH), .WIDTH(TAG_W)) u_tags (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_data (TAG_W'(req1_ack)),
      .pop       (pop),
      .pop_data  (head_tag),
      .full      (full),
      .empty     (empty),
      .count     (count)
   );

   always_comb begin
      state_nxt = state;
      case (state)
         RUN:     if (drain)  state_nxt = DRAIN;
         DRAIN:   if (!drain) state_nxt = RUN;
         default: state_nxt = RUN;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state      <= RUN;
         prio       <= 1'b0;
         mul_ready  <= 1'b0;
         mul_op1    <= '0;
         mul_op2    <= '0;
         res0_valid <= 1'b0;
         res1_valid <= 1'b0;
         res_data   <= '0;
         err        <= 1'b0;
      end else begin
         state     <= state_nxt;
         mul_ready <= push;
         if (push) begin
            prio    <= req0_ack;
            mul_op1 <= req1_ack ? req1_op1 : req0_op1;
            mul_op2 <= req1_ack ? req1_op2 : req0_op2;
         end
         res0_valid <= pop && (head_tag == TAG_W'(0));
         res1_valid <= pop && (head_tag == TAG_W'(1));
         if (pop) res_data <= mul_res;
         if (mul_done && empty) err <= 1'b1;
      end
   end
endmodule

// File: tb/tb_fpmul_arbiter.sv
// Bench for fpmul_arbiter: a 17-cycle multiplier model feeds a scoreboard on a
// default-depth instance, plus hand-driven full/drain sequences on a DEPTH=4 instance.
module tb_fpmul_arbiter;
   import fpmul_arbiter_pkg::*;
   localparam int LAT = MUL_LATENCY;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic        req0_valid, req1_valid, req0_ack, req1_ack, mul_ready, mul_done;
   logic [31:0] req0_op1, req0_op2, req1_op1, req1_op2, mul_op1, mul_op2, mul_res, res_data;
   logic        res0_valid, res1_valid, drain, idle, err;

   logic        s_req0_valid, s_req1_valid, s_req0_ack, s_req1_ack, s_mul_ready, s_mul_done;
   logic [31:0] s_req0_op1, s_req0_op2, s_req1_op1, s_req1_op2, s_mul_op1, s_mul_op2, s_mul_res, s_res_data;
   logic        s_res0_valid, s_res1_valid, s_drain, s_idle, s_err;

   fpmul_arbiter u_big (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_op1(req0_op1), .req0_op2(req0_op2), .req0_ack(req0_ack),
      .req1_valid(req1_valid), .req1_op1(req1_op1), .req1_op2(req1_op2), .req1_ack(req1_ack),
      .mul_ready(mul_ready), .mul_op1(mul_op1), .mul_op2(mul_op2),
      .mul_done(mul_done), .mul_res(mul_res),
      .res0_valid(res0_valid), .res1_valid(res1_valid), .res_data(res_data),
      .drain(drain), .idle(idle), .err(err)
   );

   fpmul_arbiter #(.DEPTH(4)) u_small (
      .clk(clk), .rst(rst),
      .req0_valid(s_req0_valid), .req0_op1(s_req0_op1), .req0_op2(s_req0_op2), .req0_ack(s_req0_ack),
      .req1_valid(s_req1_valid), .req1_op1(s_req1_op1), .req1_op2(s_req1_op2), .req1_ack(s_req1_ack),
      .mul_ready(s_mul_ready), .mul_op1(s_mul_op1), .mul_op2(s_mul_op2),
      .mul_done(s_mul_done), .mul_res(s_mul_res),
      .res0_valid(s_res0_valid), .res1_valid(s_res1_valid), .res_data(s_res_data),
      .drain(s_drain), .idle(s_idle), .err(s_err)
   );

   typedef struct packed { logic tag; logic [31:0] data; int acc; } exp_t;
   typedef struct packed { logic v; logic [31:0] a; logic [31:0] b; } stage_t;
   typedef struct packed { logic [31:0] op1; logic [31:0] op2; } vec_t;

   exp_t   sb[$];
   int     grants[$];
   stage_t pipe [LAT];
   vec_t   b2b [40];
   int     checks, failures, cyc, inflight, max_inflight;
   logic   ack0_n, ack1_n, s_ack0_n, exp_ready;
   logic [31:0] exp_op1, exp_op2;

   // Stand-in for the external multiplier: exact for the named vectors, a
   // deterministic scramble otherwise (the arbiter only forwards it).
   function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
      if (a == 32'h40000000 && b == 32'h40200000) return 32'h40A00000;
      if (b == 32'h3F800000) return a;
      return a ^ {b[15:0], b[31:16]};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic clear_model();
      for (int i = 0; i < LAT; i++) pipe[i] = '0;
      sb.delete();
      inflight = 0;
      mul_done = 1'b0;
      mul_res  = '0;
   endtask

   task automatic step();
      exp_t e;
      @(negedge clk);
      ack0_n   = req0_ack;
      ack1_n   = req1_ack;
      s_ack0_n = s_req0_ack;
      if (ack0_n || ack1_n) begin
         chk("one_ack", {ack1_n, ack0_n}, ack1_n ? 32'd2 : 32'd1);
         e.tag  = ack1_n;
         e.data = ack1_n ? fmul(req1_op1, req1_op2) : fmul(req0_op1, req0_op2);
         e.acc  = cyc;
         sb.push_back(e);
         grants.push_back(ack1_n ? 1 : 0);
      end
      inflight = inflight + ((ack0_n || ack1_n) ? 1 : 0) - ((mul_done && inflight > 0) ? 1 : 0);
      if (inflight > max_inflight) max_inflight = inflight;
      exp_ready = ack0_n || ack1_n;
      exp_op1   = ack1_n ? req1_op1 : req0_op1;
      exp_op2   = ack1_n ? req1_op2 : req0_op2;
      @(posedge clk);
      #1;
      cyc++;
      chk("mul_ready", mul_ready, exp_ready);
      if (exp_ready) begin
         chk("mul_op1", mul_op1, exp_op1);
         chk("mul_op2", mul_op2, exp_op2);
      end
      if (res0_valid || res1_valid) begin
         if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_res: got res0=%b res1=%b data=%h required none", res0_valid, res1_valid, res_data);
         end else begin
            e = sb.pop_front();
            chk("res_route", {res1_valid, res0_valid}, e.tag ? 32'd2 : 32'd1);
            chk("res_data", res_data, e.data);
            chk("latency", cyc - e.acc, LAT + 2);
         end
      end
      mul_done = pipe[LAT-1].v;
      mul_res  = pipe[LAT-1].v ? fmul(pipe[LAT-1].a, pipe[LAT-1].b) : '0;
      for (int i = LAT-1; i > 0; i--) pipe[i] = pipe[i-1];
      pipe[0] = {mul_ready, mul_op1, mul_op2};
   endtask

   task automatic wait_empty(input int budget);
      int n = 0;
      while (sb.size() != 0 && n < budget) begin
         step();
         n++;
      end
      chk("drain_timeout", sb.size(), 0);
   endtask

   task automatic chk_reset();
      chk("rst_idle", idle, 1);
      chk("rst_err", err, 0);
      chk("rst_mul_ready", mul_ready, 0);
      chk("rst_mul_op1", mul_op1, 0);
      chk("rst_mul_op2", mul_op2, 0);
      chk("rst_res_valid", {res1_valid, res0_valid}, 0);
      chk("rst_res_data", res_data, 0);
   endtask

   initial begin
      checks = 0; failures = 0; cyc = 0; max_inflight = 0;
      rst = 1'b0; drain = 1'b0;
      req0_valid = 0; req1_valid = 0;
      req0_op1 = 32'h40000000; req0_op2 = 32'h40200000;
      req1_op1 = 32'h3FA00000; req1_op2 = 32'h3F800000;
      s_req0_valid = 0; s_req1_valid = 0; s_drain = 0; s_mul_done = 0; s_mul_res = '0;
      s_req0_op1 = 32'h41000000; s_req0_op2 = 32'h3F000000; s_req1_op1 = '0; s_req1_op2 = '0;
      clear_model();

      // Reset: acks suppressed even with a request pending
      step();
      req0_valid = 1;
      step();
      chk("ack_in_reset", {ack1_n, ack0_n}, 0);
      req0_valid = 0;
      chk_reset();
      chk("s_rst_idle", s_idle, 1);
      rst = 1'b1;
      step();

      // Contention: strict alternation starting at requester 0
      grants.delete();
      req0_valid = 1; req1_valid = 1;
      repeat (4) step();
      req0_valid = 0; req1_valid = 0;
      chk("rr_count", grants.size(), 4);
      for (int i = 0; i < grants.size(); i++) chk("rr_grant", grants[i], i % 2);
      wait_empty(40);

      // Single request on requester 0
      req0_valid = 1;
      step();
      chk("single_ack", ack0_n, 1);
      req0_valid = 0;
      wait_empty(40);
      chk("idle_after_single", idle, 1);

      // Back-to-back on requester 1
      for (int i = 0; i < 40; i++) b2b[i] = {32'h3F800000 + (i << 12), 32'h40400000 + i * 3};
      max_inflight = 0;
      req1_valid = 1;
      for (int i = 0; i < 40; i++) begin
         req1_op1 = b2b[i].op1;
         req1_op2 = b2b[i].op2;
         step();
         chk("b2b_ack", ack1_n, 1);
      end
      req1_valid = 0;
      wait_empty(80);
      chk("b2b_max_outstanding", max_inflight <= 18, 1);

      // Stray mul_done sets sticky err, no result
      mul_done = 1; mul_res = 32'hDEADBEEF;
      step();
      chk("err_set", err, 1);
      chk("err_no_res", {res1_valid, res0_valid}, 0);
      step();
      chk("err_sticky", err, 1);

      // Reset with three operations in flight
      req0_valid = 1;
      repeat (3) step();
      req0_valid = 0;
      step();
      step();
      chk("busy_before_rst", idle, 0);
      rst = 1'b0;
      step();
      chk_reset();
      clear_model();
      rst = 1'b1;
      repeat (3) step();
      chk("idle_after_rst", idle, 1);

      // DEPTH=4: fill, block, pop-assisted accept, drain
      s_req0_valid = 1;
      for (int i = 0; i < 4; i++) begin
         step();
         chk("s_fill_ack", s_ack0_n, 1);
      end
      repeat (3) begin
         step();
         chk("s_full_block", s_ack0_n, 0);
      end
      chk("s_busy", s_idle, 0);
      s_mul_done = 1; s_mul_res = 32'h11111111;
      step();
      chk("s_pop_accept", s_ack0_n, 1);
      s_mul_done = 0; s_req0_valid = 0;
      chk("s_res0_valid", s_res0_valid, 1);
      chk("s_res_data", s_res_data, 32'h11111111);
      s_drain = 1;
      step();
      s_req0_valid = 1;
      step();
      chk("s_drain_block", s_ack0_n, 0);
      for (int k = 0; k < 4; k++) begin
         s_mul_done = 1; s_mul_res = 32'h20000000 + k;
         step();
         chk("s_drain_no_ack", s_ack0_n, 0);
         chk("s_drain_res_valid", {s_res1_valid, s_res0_valid}, 1);
         chk("s_drain_res_data", s_res_data, 32'h20000000 + k);
         chk("s_idle", s_idle, (k == 3) ? 1 : 0);
      end
      s_mul_done = 0; s_req0_valid = 0; s_drain = 0;
      step();
      chk("s_err_clear", s_err, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
